// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: forwarding-select codes, producer latencies
// and the per-register scoreboard entry.
package pipe_pkg;

    localparam int FWD_RF   = 0;
    localparam int FWD_EX   = 1;
    localparam int FWD_MEM  = 2;
    localparam int FWD_WB   = 3;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    // Wide enough for any pipeline depth up to 15 stages after ID.
    localparam int ENT_W    = 4;

    typedef struct packed {
        logic             busy;
        logic [ENT_W-1:0] pos;
        logic [ENT_W-1:0] rdy;
    } entry_t;

    // A consumer in ID needs the value one stage earlier than one in EX.
    function automatic logic src_hazard(input entry_t e, input logic used, input logic id_use);
        if (!(used && e.busy)) begin
            return 1'b0;
        end
        return id_use ? (e.pos <= e.rdy) : (e.pos < e.rdy);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's in-flight producer: stage position and result-ready stage.
module sb_entry
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             set,
    input  logic [ENT_W-1:0] set_rdy,
    output entry_t           ent
);

    entry_t ent_q;
    entry_t ent_d;

    // A new issue wins over the advance/retire of an older producer.
    always_comb begin
        ent_d = ent_q;
        if (set) begin
            ent_d.busy = 1'b1;
            ent_d.pos  = ENT_W'(1);
            ent_d.rdy  = set_rdy;
        end else if (!hold && ent_q.busy) begin
            if (ent_q.pos >= ENT_W'(DEPTH)) begin
                ent_d = '0;
            end else begin
                ent_d.pos = ent_q.pos + ENT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign ent = ent_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard/forwarding controller: ID stall, ID bypass selects and
// registered EX bypass selects derived from per-register producer state.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int RW    = $clog2(NREG),
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic [RW-1:0] issue_rs,
    input  logic [RW-1:0] issue_rt,
    input  logic          issue_rs_used,
    input  logic          issue_rt_used,
    input  logic          issue_id_use,
    input  logic          issue_wr_en,
    input  logic [RW-1:0] issue_wr_reg,
    input  logic [SW-1:0] issue_lat,
    input  logic          hold,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] id_fwd_a,
    output logic [SW-1:0] id_fwd_b,
    output logic [SW-1:0] ex_fwd_a,
    output logic [SW-1:0] ex_fwd_b,
    output logic [31:0]   stall_cnt
);

    entry_t        ents [NREG];
    entry_t        ent_a;
    entry_t        ent_b;
    logic          hazard_a;
    logic          hazard_b;
    logic          accept;
    logic          wr_set;
    logic [SW-1:0] ex_fwd_a_q, ex_fwd_a_d;
    logic [SW-1:0] ex_fwd_b_q, ex_fwd_b_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;

    // Register 0 never has a producer, so it reads as an idle entry.
    assign ents[0] = '0;

    assign wr_set = accept && issue_wr_en && (issue_wr_reg != '0);

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_ent
            sb_entry #(.DEPTH(DEPTH)) u_entry (
                .clk     (clk),
                .reset   (reset),
                .hold    (hold),
                .set     (wr_set && (issue_wr_reg == RW'(gi))),
                .set_rdy (ENT_W'(issue_lat)),
                .ent     (ents[gi])
            );
        end
    endgenerate

    assign ent_a    = ents[issue_rs];
    assign ent_b    = ents[issue_rt];
    assign hazard_a = src_hazard(ent_a, issue_rs_used, issue_id_use);
    assign hazard_b = src_hazard(ent_b, issue_rt_used, issue_id_use);

    assign stall  = hold | (issue_valid & (hazard_a | hazard_b));
    assign accept = issue_valid & ~stall & ~flush;

    assign id_fwd_a = (issue_rs_used && ent_a.busy) ? ent_a.pos[SW-1:0] : '0;
    assign id_fwd_b = (issue_rt_used && ent_b.busy) ? ent_b.pos[SW-1:0] : '0;

    // By the time the consumer reaches EX the producer has moved one stage on.
    function automatic logic [SW-1:0] ex_sel(input entry_t e, input logic used);
        if (used && e.busy && !issue_id_use && (e.pos < ENT_W'(DEPTH))) begin
            return SW'(e.pos + ENT_W'(1));
        end
        return '0;
    endfunction

    always_comb begin
        ex_fwd_a_d  = ex_fwd_a_q;
        ex_fwd_b_d  = ex_fwd_b_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            ex_fwd_a_d = accept ? ex_sel(ent_a, issue_rs_used) : '0;
            ex_fwd_b_d = accept ? ex_sel(ent_b, issue_rt_used) : '0;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_fwd_a_q  <= '0;
            ex_fwd_b_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_fwd_a_q  <= ex_fwd_a_d;
            ex_fwd_b_q  <= ex_fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_fwd_a  = ex_fwd_a_q;
    assign ex_fwd_b  = ex_fwd_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule
